lockin_seq: RTL
===============

LOCKIN_SEQ -- requirements
Module: lockin_seq

Interface
REQ-001 Parameter Q_SUMAS, default 32, width of the lock-in accumulator results.
REQ-002 Parameter TO_W, default 24, width of the RUN-state timeout counter and limit.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to begin an acquisition sequence.
REQ-006 stop  in  1  level; aborts RUN and ends continuous mode.
REQ-007 continuous  in  1  level; when 1, acquisitions re-arm automatically.
REQ-008 timeout_lim  in  TO_W  maximum RUN cycles; 0 disables the timeout.
REQ-009 adc_valid  in  1  sample strobe from the ADC front end.
REQ-010 lk_rst_n  out  1  active-low clear to the lock-in core.
REQ-011 lk_x_valid  out  1  gated sample strobe to the lock-in core.
REQ-012 lk_fase, lk_cuad  in  Q_SUMAS each  signed lock-in accumulator outputs.
REQ-013 lk_done  in  1  lock-in done level; high once N periods are accumulated.
REQ-014 res_fase, res_cuad  out  Q_SUMAS each  captured signed results.
REQ-015 res_valid  out  1  captured result pending for the host.
REQ-016 res_ack  in  1  host consumed the result; single-cycle pulse.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 overrun, timeout  out  1 each  sticky error flags.
REQ-019 seq_count  out  16  number of completed captures since the last accepted start.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, RUN, CAPTURE; encoding is free.
REQ-021 In IDLE: lk_rst_n=0, lk_x_valid=0; start=1 SHALL go to CLEAR and clear overrun, timeout and seq_count; start outside IDLE SHALL be ignored.
REQ-022 CLEAR SHALL last exactly 1 cycle with lk_rst_n=0, then go to RUN.
REQ-023 Latency: start sampled at edge t means CLEAR during cycle t+1 and lk_rst_n=1 from edge t+2.
REQ-024 In RUN: lk_rst_n=1 and lk_x_valid=adc_valid combinationally; in all other states lk_x_valid=0.
REQ-025 In RUN, a 0-based TO_W-bit counter SHALL increment every cycle; it SHALL be cleared on RUN entry.
REQ-026 RUN priority: stop -> IDLE first; then lk_done -> CAPTURE; then (timeout_lim!=0 and counter==timeout_lim-1) -> IDLE with timeout set to 1.
REQ-027 In CAPTURE (1 cycle): res_fase<=lk_fase, res_cuad<=lk_cuad, res_valid<=1, seq_count<=seq_count+1 (wraps at 0xFFFF->0); lk_rst_n=1 so the core outputs stay stable.
REQ-028 If res_valid=1 and res_ack=0 on CAPTURE, results SHALL be overwritten and overrun set to 1.
REQ-029 res_ack together with CAPTURE SHALL leave res_valid=1 with no overrun; res_ack alone SHALL clear res_valid next edge.
REQ-030 From CAPTURE: continuous=1 and stop=0 -> CLEAR; otherwise -> IDLE.
REQ-031 stop in CLEAR SHALL go to IDLE; stop in IDLE has no effect.
REQ-032 res_fase/res_cuad SHALL hold their value until the next CAPTURE or reset; start does not clear them.
REQ-033 overrun and timeout SHALL remain set until the next accepted start or reset.

Reset
REQ-034 With reset_n=0, asynchronously: state=IDLE, lk_rst_n=0, lk_x_valid=0, res_fase=0, res_cuad=0, res_valid=0, busy=0, overrun=0, timeout=0, seq_count=0, timeout counter=0.
REQ-035 Reset asserted mid-RUN SHALL abort immediately; after release the block stays in IDLE until start.

Verification
REQ-036 Single shot: continuous=0, start, lk_done after 200 RUN cycles with lk_fase=0x00001234 and lk_cuad=0xFFFFFF00 -> one CAPTURE, res_valid=1, res_fase=0x00001234, res_cuad=0xFFFFFF00, seq_count=1, then IDLE.
REQ-037 Continuous, host never acks, 3 done events -> seq_count=3, overrun=1, res_* = third capture; then stop -> IDLE after the current CAPTURE.
REQ-038 timeout_lim=10, lk_done never asserted -> IDLE after exactly 10 RUN cycles, timeout=1; next start clears timeout to 0.
REQ-039 res_ack in the same cycle as CAPTURE -> res_valid stays 1 and overrun=0; res_ack on a later cycle -> res_valid=0 on the next edge.
REQ-040 reset_n pulled low in RUN with adc_valid=1 -> lk_x_valid=0 and lk_rst_n=0 immediately, all outputs at reset values; start issued during CLEAR -> ignored.

Source files
------------

// File: rtl/lockin_seq_if.sv
// Bundles the lock-in core bus and the host result handshake between the
// acquisition sequencer (master) and the core/host side (slave).
interface lockin_seq_if #(
    parameter int Q_SUMAS = 32
);
    logic                      lk_rst_n;
    logic                      lk_x_valid;
    logic signed [Q_SUMAS-1:0] lk_fase;
    logic signed [Q_SUMAS-1:0] lk_cuad;
    logic                      lk_done;
    logic signed [Q_SUMAS-1:0] res_fase;
    logic signed [Q_SUMAS-1:0] res_cuad;
    logic                      res_valid;
    logic                      res_ack;

    modport master (
        output lk_rst_n, lk_x_valid, res_fase, res_cuad, res_valid,
        input  lk_fase, lk_cuad, lk_done, res_ack
    );

    modport slave (
        input  lk_rst_n, lk_x_valid, res_fase, res_cuad, res_valid,
        output lk_fase, lk_cuad, lk_done, res_ack
    );
endinterface

// File: rtl/lockin_seq.sv
// Acquisition sequencer for a lock-in core: clears the core, gates ADC samples
// while running, captures results for the host and tracks overrun/timeout.
module lockin_seq #(
    parameter int Q_SUMAS = 32,
    parameter int TO_W    = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [TO_W-1:0]   timeout_lim,
    input  logic              adc_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [15:0]       seq_count,
    lockin_seq_if.master      bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE
    } state_t;

    state_t                    state_q, state_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic signed [Q_SUMAS-1:0] res_fase_q, res_fase_d;
    logic signed [Q_SUMAS-1:0] res_cuad_q, res_cuad_d;
    logic                      res_valid_q, res_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      timeout_q, timeout_d;
    logic [15:0]               seq_count_q, seq_count_d;
    logic                      to_hit;

    assign to_hit = (timeout_lim != '0) && (to_cnt_q == timeout_lim - TO_W'(1));

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        res_fase_d  = res_fase_q;
        res_cuad_d  = res_cuad_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        seq_count_d = seq_count_q;

        // An ack outside CAPTURE retires the pending result; CAPTURE below overrides it.
        if (bus.res_ack) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    overrun_d   = 1'b0;
                    timeout_d   = 1'b0;
                    seq_count_d = '0;
                end
            end
            S_CLEAR: begin
                to_cnt_d = '0;
                state_d  = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (bus.lk_done) begin
                    state_d = S_CAPTURE;
                end else if (to_hit) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                res_fase_d  = bus.lk_fase;
                res_cuad_d  = bus.lk_cuad;
                res_valid_d = 1'b1;
                seq_count_d = seq_count_q + 16'd1;
                if (res_valid_q && !bus.res_ack) begin
                    overrun_d = 1'b1;
                end
                state_d = (continuous && !stop) ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            res_fase_q  <= '0;
            res_cuad_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            seq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            res_fase_q  <= res_fase_d;
            res_cuad_q  <= res_cuad_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            seq_count_q <= seq_count_d;
        end
    end

    // The core is held cleared except while accumulating or being read out.
    assign bus.lk_rst_n   = (state_q == S_RUN) || (state_q == S_CAPTURE);
    assign bus.lk_x_valid = (state_q == S_RUN) && adc_valid;
    assign bus.res_fase   = res_fase_q;
    assign bus.res_cuad   = res_cuad_q;
    assign bus.res_valid  = res_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;
    assign seq_count      = seq_count_q;
endmodule
